spi_mcp_multi: RTL

SPI_MCP_MULTI -- requirements
Module: spi_mcp_multi

---
 rtl/spi_mcp_multi.sv | 125 ++++++++++++
 1 files changed

// File: rtl/spi_mcp_multi.sv
// Multi-lane SPI driver for MCP-style dual-channel 12-bit DACs: every lane shifts
// a channel-A word then a channel-B word on shared sclk/cs_n, followed by a lat_n pulse.
module spi_mcp_multi #(
    parameter int LANES  = 3,
    parameter int DATA_W = 12,
    parameter int DIV    = 4,
    parameter int GAIN1X = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [LANES*DATA_W-1:0]   dac_a,
    input  logic [LANES*DATA_W-1:0]   dac_b,
    input  logic                      load,
    output logic                      ready,
    output logic                      dac_sclk,
    output logic                      dac_cs_n,
    output logic                      dac_lat_n,
    output logic [LANES-1:0]          dac_sdat,
    output logic                      frame_done
);

    localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DIV - 1);
    localparam int                PAD      = 12 - DATA_W;
    localparam logic              GAIN_BIT = (GAIN1X != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WORD_A, S_GAP, S_WORD_B, S_LATCH, S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [LANES*DATA_W-1:0]   act_a, act_b, pend_a, pend_b;
    logic                      pend_valid;
    logic                      accept, in_word, div_last, word_end;
    logic [CNT_W-1:0]          div_cnt;
    logic                      phase;
    logic [3:0]                bit_cnt;
    logic [3:0]                bit_idx;

    assign ready    = !pend_valid;
    assign accept   = load && ready;
    assign in_word  = (state == S_WORD_A) || (state == S_WORD_B);
    assign div_last = (div_cnt == DIV_LAST);
    assign word_end = in_word && div_last && phase && (bit_cnt == 4'd15);
    assign bit_idx  = 4'd15 - bit_cnt;

    // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (accept)   state_nxt = S_WORD_A;
            S_WORD_A: if (word_end) state_nxt = S_GAP;
            S_GAP:    if (div_last) state_nxt = S_WORD_B;
            S_WORD_B: if (word_end) state_nxt = S_LATCH;
            S_LATCH:  if (div_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = (pend_valid || accept) ? S_WORD_A : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the sample shadows are plain registers, so they take the reset like any other state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            act_a      <= '0;
            act_b      <= '0;
            pend_a     <= '0;
            pend_b     <= '0;
            pend_valid <= 1'b0;
        end else if (state == S_DONE && pend_valid) begin
            act_a      <= pend_a;
            act_b      <= pend_b;
            pend_valid <= 1'b0;
        end else if (accept && (state == S_IDLE || state == S_DONE)) begin
            // An idle DONE starts the next frame directly, exactly as a pending hand-over would.
            act_a <= dac_a;
            act_b <= dac_b;
        end else if (accept) begin
            pend_a     <= dac_a;
            pend_b     <= dac_b;
            pend_valid <= 1'b1;
        end
    end

    // Counters restart on every state change; phase 0 is sclk low, phase 1 sclk high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (state_nxt != state) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + CNT_W'(1);
            if (in_word && div_last) begin
                phase <= !phase;
                if (phase) bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        dac_sclk   = in_word && phase;
        dac_cs_n   = !in_word;
        dac_lat_n  = (state != S_LATCH);
        frame_done = (state == S_DONE);
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] sample;
        logic [15:0]       word;
        assign sample      = (state == S_WORD_B) ? act_b[k*DATA_W +: DATA_W]
                                                 : act_a[k*DATA_W +: DATA_W];
        assign word        = {state == S_WORD_B, 1'b0, GAIN_BIT, 1'b1, 12'(sample) << PAD};
        assign dac_sdat[k] = in_word && word[bit_idx];
    end

endmodule
